pool2d_stream: RTL and testbench
================================

POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, signed pixel width.
REQ-002 SHALL have parameter FM_W, default 6, input feature-map width; even, at least 2.
REQ-003 SHALL have parameter FM_H, default 6, input feature-map height; even, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begins one frame when sampled high in IDLE.
REQ-007 SHALL have port mode, input, 1, 0 = average pool, 1 = max pool; latched on accepted start.
REQ-008 SHALL have port in_valid, input, 1, in_data valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept in_data.
REQ-010 SHALL have port in_data, input, DATA_W, signed pixel, raster order (row-major).
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-013 SHALL have port out_data, output, DATA_W, signed pooled pixel.
REQ-014 SHALL have port out_last, output, 1, high with the final output of a frame.
REQ-015 SHALL have port busy, output, 1, high from accepted start until done.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-017 SHALL pool 2x2 windows, stride 2, producing (FM_W/2)*(FM_H/2) outputs per frame, raster order.
REQ-018 SHALL treat a transfer as occurring only in a cycle where valid and ready are both high, on each port independently.
REQ-019 SHALL use states IDLE -> RUN on start; RUN -> DRAIN after the FM_W*FM_H-th input transfer; DRAIN -> DONE when the out_last transfer occurs; DONE -> IDLE unconditionally next cycle.
REQ-020 SHALL pulse done for exactly the cycle the state is DONE; busy high in RUN, DRAIN, DONE.
REQ-021 SHALL ignore start outside IDLE; in_ready SHALL be low in IDLE, DRAIN, DONE.
REQ-022 SHALL store even-row pixels in a single FM_W-entry line buffer; SHALL hold the even-column pixel of odd rows in one register.
REQ-023 SHALL register the window result into out_data/out_valid the cycle after the transfer of the window's fourth pixel (odd row, odd column): one-cycle latency.
REQ-024 Average mode SHALL sum the four pixels in DATA_W+2 bits and arithmetically shift right by 2 (floor), truncated to DATA_W.
REQ-025 Max mode SHALL output the largest of the four pixels by signed comparison.
REQ-026 SHALL hold out_data, out_valid, out_last stable while out_valid high and out_ready low.
REQ-027 SHALL drive in_ready low while out_valid is high and out_ready is low (no result lost under backpressure).
REQ-028 When an output transfers in the same cycle a new window completes, SHALL load the new result with out_valid staying high.
REQ-029 SHALL set row/column counters to wrap column at FM_W and row at FM_H; no input accepted past the last pixel of a frame.
REQ-030 A new frame SHALL start only from IDLE; mode change during a frame SHALL have no effect.

Reset
REQ-031 On rst SHALL enter IDLE within the same edge, overriding any activity, including mid-frame.
REQ-032 Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, counters 0, latched mode 0.
REQ-033 Line buffer contents need not be reset; outputs SHALL never depend on stale buffer data.

Configuration
REQ-034 Macro POOL_RELU_EN: when defined, out_data SHALL be max(result, 0) for both modes, same latency.
REQ-035 Without POOL_RELU_EN, out_data SHALL be the unclamped signed result.

Verification
REQ-036 6x6 frame, pixels 0..35, mode 0, out_ready 1 -> outputs 3,5,7,15,17,19,27,29,31; out_last with 31; done one cycle after.
REQ-037 Same frame, mode 1 -> outputs 7,9,11,19,21,23,31,33,35.
REQ-038 FM_W=FM_H=2, pixels -1,-2,-3,-4, mode 0 -> out_data -3 (-10>>2); mode 1 -> -1; with POOL_RELU_EN both -> 0.
REQ-039 Run REQ-036 with out_ready toggling 1,0,0 repeatedly -> identical output sequence, in_ready low whenever out_valid and not out_ready, no drops.
REQ-040 Assert rst after 20 input transfers -> next cycle busy 0, out_valid 0, in_ready 0; fresh start with REQ-036 stimulus reproduces REQ-036 outputs.
REQ-041 Pulse start and toggle mode during RUN -> no restart, output matches mode latched at first start.

Source files
------------

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 average or max pooling over a raster-order feature map.
// Optional POOL_RELU_EN clamps every pooled result to zero or above.
module pool2d_stream #(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = (FM_W > 2) ? $clog2(FM_W) : 1;
    localparam int RW = (FM_H > 2) ? $clog2(FM_H) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]            col_q;
    logic [RW-1:0]            row_q;
    logic                     mode_q;
    logic signed [DATA_W-1:0] lb [FM_W];
    logic signed [DATA_W-1:0] hold_q;

    logic                     in_fire, out_fire, win_fire, last_pix;
    logic [CW-1:0]            col_pair;
    logic signed [DATA_W-1:0] pa, pb, pc, pd;
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W-1:0] avg, max_ab, max_cd, max_all, pooled, result;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_pix = (row_q == RW'(FM_H - 1)) && (col_q == CW'(FM_W - 1));
    assign win_fire = in_fire && row_q[0] && col_q[0];
    assign col_pair = col_q - CW'(1);

    assign in_ready = (state_q == StRun) && !(out_valid && !out_ready);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (in_fire && last_pix) state_d = StDrain;
            StDrain: if (out_fire && out_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Window: top pair from the line buffer, bottom pair from hold + current pixel.
    always_comb begin
        pa      = lb[col_pair];
        pb      = lb[col_q];
        pc      = hold_q;
        pd      = in_data;
        sum     = $signed({{2{pa[DATA_W-1]}}, pa}) + $signed({{2{pb[DATA_W-1]}}, pb})
                + $signed({{2{pc[DATA_W-1]}}, pc}) + $signed({{2{pd[DATA_W-1]}}, pd});
        avg     = sum[DATA_W+1:2];
        max_ab  = (pa > pb) ? pa : pb;
        max_cd  = (pc > pd) ? pc : pd;
        max_all = (max_ab > max_cd) ? max_ab : max_cd;
        pooled  = mode_q ? max_all : avg;
`ifdef POOL_RELU_EN
        result  = pooled[DATA_W-1] ? '0 : pooled;
`else
        result  = pooled;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                mode_q <= mode;
                col_q  <= '0;
                row_q  <= '0;
            end else if (in_fire) begin
                if (col_q == CW'(FM_W - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == RW'(FM_H - 1)) ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (win_fire) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_last  <= last_pix;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Pixel storage is write-before-read per frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire && !row_q[0]) lb[col_q] <= in_data;
        if (in_fire && row_q[0] && !col_q[0]) hold_q <= in_data;
    end

endmodule

// File: tb/tb_pool2d_stream.sv
// Randomized self-checking bench for pool2d_stream against a queue-based window model.
module tb_pool2d_stream;
    localparam int NP = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic signed [31:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, done;
    logic signed [31:0] out_data;

    logic s_start = 1'b0, s_mode = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
    logic signed [31:0] s_in_data = '0;
    logic s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
    logic signed [31:0] s_out_data;

    pool2d_stream #(.DATA_W(32), .FM_W(6), .FM_H(6)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    pool2d_stream #(.DATA_W(32), .FM_W(2), .FM_H(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_data(s_in_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
        .busy(s_busy), .done(s_done)
    );

    typedef struct {logic [31:0] data; logic last;} exp_t;
    exp_t q[$];

    logic signed [31:0] pix [NP];
    int checks = 0, errors = 0;
    int rdy_mode = 0, rdy_phase = 0, done_count = 0;
    bit prev_stall = 0, last_xfer = 0, prev_last = 0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic signed [31:0] v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic longint px(input int r, input int c);
        return longint'(pix[r * 6 + c]);
    endfunction

    // Reference: plain arithmetic over the four window pixels.
    function automatic logic [31:0] window_ref(input int m, input int r, input int c);
        longint v[4];
        longint s, mx;
        v[0] = px(2 * r, 2 * c);     v[1] = px(2 * r, 2 * c + 1);
        v[2] = px(2 * r + 1, 2 * c); v[3] = px(2 * r + 1, 2 * c + 1);
        s = v[0] + v[1] + v[2] + v[3];
        mx = v[0];
        for (int k = 1; k < 4; k++) if (v[k] > mx) mx = v[k];
        if (m != 0) return relu(32'(mx));
        return relu(32'(s >>> 2));
    endfunction

    task automatic push_frame(input int m);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                q.push_back('{window_ref(m, r, c), (r == 2 && c == 2)});
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rdy_phase == 0); rdy_phase = (rdy_phase + 1) % 3; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            last_xfer  = 0;
        end else begin
            check("done_pulse", {31'd0, done}, {31'd0, last_xfer});
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && !out_ready) check("in_ready_bp", {31'd0, in_ready}, 32'd0);
            last_xfer = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                    last_xfer = out_last;
                    if (out_last) done_count++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_frame(input int m, input int limit, input bit mess);
        int i, cyc, d0;
        bit fire;
        d0 = done_count;
        push_frame(m);
        @(posedge clk); #1 start = 1'b1; mode = m[0];
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check("busy_run", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        i = 0; cyc = 0;
        while (i < limit && cyc < 5000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = pix[i];
            if (mess) begin start = 1'($urandom_range(0, 1)); mode = 1'($urandom_range(0, 1)); end
            @(negedge clk); fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        if (cyc >= 5000) check("input_timeout", 32'd1, 32'd0);
        if (limit == NP) begin
            cyc = 0;
            while (done_count == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
            if (cyc >= 3000) check("done_timeout", 32'd1, 32'd0);
            @(negedge clk); @(negedge clk);
            check("busy_idle", {31'd0, busy}, 32'd0);
            check("pending", q.size(), 32'd0);
        end
    endtask

    task automatic small_frame(input int m, input logic [31:0] exp);
        logic signed [31:0] tv [4];
        int k, cyc;
        bit f;
        tv[0] = -1; tv[1] = -2; tv[2] = -3; tv[3] = -4;
        @(posedge clk); #1 s_start = 1'b1; s_mode = m[0];
        @(posedge clk); #1 s_start = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 50) begin
            s_in_valid = 1'b1; s_in_data = tv[k];
            @(negedge clk); f = s_in_ready;
            @(posedge clk); #1;
            if (f) k++;
            cyc++;
        end
        s_in_valid = 1'b0;
        @(negedge clk);
        check("small_valid", {31'd0, s_out_valid}, 32'd1);
        check("small_data", s_out_data, exp);
        check("small_last", {31'd0, s_out_last}, 32'd1);
        repeat (3) @(negedge clk);
        check("small_busy", {31'd0, s_busy}, 32'd0);
    endtask

    task automatic ramp();
        for (int k = 0; k < NP; k++) pix[k] = k;
    endtask

    initial begin
        int lit_avg [9];
        int lit_max [9];
        lit_avg = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        lit_max = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        ramp();
        for (int k = 0; k < 9; k++) begin
            check("model_avg", window_ref(0, k / 3, k % 3), lit_avg[k]);
            check("model_max", window_ref(1, k / 3, k % 3), lit_max[k]);
        end

        rdy_mode = 0; run_frame(0, NP, 0);
        run_frame(1, NP, 0);
        rdy_mode = 1; rdy_phase = 0; run_frame(0, NP, 0);

        // Mid-frame reset, then a clean frame.
        rdy_mode = 2; run_frame(0, 20, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        #1 rst = 1'b0;
        rdy_mode = 0; run_frame(0, NP, 0);

        for (int k = 0; k < NP; k++) pix[k] = $signed($urandom_range(0, 2000)) - 1000;
        rdy_mode = 2; run_frame(1, NP, 1);
        run_frame(0, NP, 1);

        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NP; k++)
                pix[k] = (f % 2 == 0) ? $urandom() : $signed($urandom_range(0, 200)) - 100;
            rdy_mode = (f % 3 == 0) ? 1 : 2;
            run_frame(int'($urandom_range(0, 1)), NP, 0);
        end

`ifdef POOL_RELU_EN
        small_frame(0, 32'd0);
        small_frame(1, 32'd0);
`else
        small_frame(0, -32'sd3);
        small_frame(1, -32'sd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
